sr_pulse_driver: RTL
====================

Name: sr_pulse_driver

Overview:
- Driver side of the cross-coupled NOR SR latch interface: turns single-cycle set/clear requests into clean, non-overlapping, width-controlled s/r pulses.
- Samples the latch's q output back through a synchronizer to confirm the latch actually changed state.
- Sits between control logic on the clk domain and an asynchronous SR latch, such as a sticky flag or an external relay or indicator latch.

Parameters:
- PULSE_W, 4: cycles s or r is held high per command; legal range 1..255.
- GAP_W, 2: cycles with s and r both low after a pulse, before q is checked; legal range 2..255 (covers the 2-flop synchronizer).
- CNT_W, 8: width of the internal duration counter; must hold max(PULSE_W, GAP_W).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_set  input  1  single-cycle request to set the latch (drive q to 1).
- req_clr  input  1  single-cycle request to clear the latch (drive q to 0).
- q_fb  input  1  latch q output; asynchronous to clk.
- s  output  1  set drive to the latch; registered.
- r  output  1  reset drive to the latch; registered.
- busy  output  1  high while a command is in progress; requests are ignored while high.
- done  output  1  one-cycle pulse when a command completes, pass or fail.
- err  output  1  one-cycle pulse: conflicting request, or latch failed to reach its target.
- q_sync  output  1  synchronized q_fb (2-flop), for use by control logic.

Behaviour:
- Reset (async assert, sync deassert by design): s=0, r=0, busy=0, done=0, err=0, q_sync=0, synchronizer flops=0, state=IDLE, counter=0. Asserting rst mid-pulse drops s/r immediately.
- Invariant: s and r are never both 1 in any cycle, including at reset and on conflicting requests.
- All outputs are registered. q_sync lags q_fb by 2 clk edges.
- State machine: IDLE, PULSE, GAP, CHECK.
- IDLE: req_set and req_clr are sampled at edge k.
  - req_set XOR req_clr: latch target (1 for set, 0 for clear). If q_sync == target, skip: at k+1, done=1, busy=1, s=r=0; return to IDLE at k+2. Otherwise go to PULSE.
  - Both requests high: no pulse. At k+1, err=1 and done=1 (busy=1); return to IDLE at k+2.
  - Neither request high: stay in IDLE.
- PULSE: cycles k+1..k+PULSE_W; s=1 if target is 1, else r=1; counter counts down.
- GAP: the next GAP_W cycles; s=r=0.
- CHECK: a single cycle, k+PULSE_W+GAP_W+1. done=1; err=1 if q_sync != target. Next edge returns to IDLE.
- busy=1 in every non-IDLE state. Requests arriving while busy=1 are dropped with no queuing and no err.
- Back-to-back operation: a new request may be sampled in the first IDLE cycle after CHECK.
- Counter never wraps: it loads PULSE_W-1 or GAP_W-1 on state entry and moves on at 0.

Optional Feature:
- Macro: SR_DRV_RETRY_EN.
- Defined: on a CHECK mismatch, re-enter PULSE once with the same target. done and err are suppressed in that first CHECK. After the retry's CHECK, done=1, and err=1 only if it still mismatches. A one-bit retry flag clears on IDLE entry.
- Undefined: the first mismatch gives err=1 with done=1, and there is no retry.

Test Plan:
Bench uses PULSE_W=4 and GAP_W=2, with a behavioural NOR latch model whose q_fb updates 1 cycle after s/r, unless stated otherwise.
1. Reset, latch q=0; req_set pulse at edge 10 -> s=1 cycles 11-14, s=r=0 cycles 15-16, done=1 and err=0 at cycle 17, busy=1 cycles 11-17, q_sync=1; r stays 0 throughout.
2. Latch q=1; req_set at edge 20 -> skip: done=1 and busy=1 at cycle 21 only, s=r=0 throughout, err=0.
3. req_set=req_clr=1 at edge 30 -> err=1 and done=1 at cycle 31; s=r=0; state IDLE at cycle 32.
4. Latch model stuck at 0; req_set -> without the macro, err=1 and done=1 at cycle k+7. With SR_DRV_RETRY_EN, a second s pulse follows at cycles k+8..k+11, then err=1 and done=1 at cycle k+14.
5. req_clr accepted with latch q=1; assert rst at cycle k+2 -> r=0 immediately (async), busy=0, done=err=0. After rst release, req_clr is accepted normally.
6. req_set during busy (cycle k+3) -> ignored, no extra pulse, single done. A req_clr on the first IDLE cycle after CHECK -> r pulse begins the next cycle.

Source files
------------

// File: rtl/sr_pulse_driver.sv
// Pulse driver for a cross-coupled NOR SR latch with q feedback check.
// Optional single retry on a failed check: define SR_DRV_RETRY_EN.
module sr_pulse_driver #(
    parameter int PULSE_W = 4,
    parameter int GAP_W   = 2,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic req_set,
    input  logic req_clr,
    input  logic q_fb,
    output logic s,
    output logic r,
    output logic busy,
    output logic done,
    output logic err,
    output logic q_sync
);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP,
        CHECK
    } state_t;

    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_W - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             tgt;
    logic             tgt_nxt;
    logic             sync1;
    logic             mism;
    logic             s_nxt;
    logic             r_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic             err_nxt;
`ifdef SR_DRV_RETRY_EN
    logic             again;
    logic             again_nxt;
    logic             retried;
    logic             retried_nxt;
`endif

    // q_fb is asynchronous to clk; two flops before any use
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= 1'b0;
            q_sync <= 1'b0;
        end else begin
            sync1  <= q_fb;
            q_sync <= sync1;
        end
    end

    assign mism = (q_sync != tgt);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        tgt_nxt   = tgt;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
`ifdef SR_DRV_RETRY_EN
        again_nxt   = 1'b0;
        retried_nxt = retried;
`endif
        case (state)
            IDLE: begin
                if (req_set && req_clr) begin
                    state_nxt = CHECK;
                    done_nxt  = 1'b1;
                    err_nxt   = 1'b1;
                end else if (req_set ^ req_clr) begin
                    tgt_nxt = req_set;
                    if (q_sync == req_set) begin
                        state_nxt = CHECK;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = PULSE;
                        cnt_nxt   = PULSE_LD;
                    end
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    state_nxt = GAP;
                    cnt_nxt   = GAP_LD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_nxt = CHECK;
`ifdef SR_DRV_RETRY_EN
                    if (mism && !retried) begin
                        again_nxt   = 1'b1;
                        retried_nxt = 1'b1;
                    end else begin
                        done_nxt = 1'b1;
                        err_nxt  = mism;
                    end
`else
                    done_nxt = 1'b1;
                    err_nxt  = mism;
`endif
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            CHECK: begin
`ifdef SR_DRV_RETRY_EN
                if (again) begin
                    state_nxt = PULSE;
                    cnt_nxt   = PULSE_LD;
                end else begin
                    state_nxt   = IDLE;
                    retried_nxt = 1'b0;
                end
`else
                state_nxt = IDLE;
`endif
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // drive levels come from the next state, so s and r are flop outputs
    // and can never be high together
    assign s_nxt    = (state_nxt == PULSE) &&  tgt_nxt;
    assign r_nxt    = (state_nxt == PULSE) && !tgt_nxt;
    assign busy_nxt = (state_nxt != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            tgt   <= 1'b0;
            s     <= 1'b0;
            r     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            tgt   <= tgt_nxt;
            s     <= s_nxt;
            r     <= r_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            err   <= err_nxt;
        end
    end

`ifdef SR_DRV_RETRY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            again   <= 1'b0;
            retried <= 1'b0;
        end else begin
            again   <= again_nxt;
            retried <= retried_nxt;
        end
    end
`endif

endmodule
